capture_ctrl: RTL and testbench
===============================

CAPTURE_CTRL -- requirements
Module: capture_ctrl

Interface
REQ-001 SHALL have parameters: DW=12, sample width; AW=8, buffer address width (depth 256); HYST=6, hysteresis in LSB; AUTO_TIMEOUT=50000, samples before a forced trigger.
REQ-002 SHALL have one clock; reset is asynchronous and active-low.
REQ-003 SHALL have ports (name, direction, width, meaning):
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- mode  in  2  00 OFF, 01 AUTO, 10 NORMAL, 11 SINGLE
- edge_sel  in  1  0 rising, 1 falling
- level  in  DW  trigger level, unsigned
- pre_trig  in  AW  pre-trigger sample count
- arm  in  1  start-capture pulse
- sample_valid  in  1  sample strobe
- sample  in  DW  ADC sample
- frame_ack  in  1  display consumed frame
- wr_en  out  1  buffer write strobe
- wr_addr  out  AW  buffer write address
- wr_data  out  DW  buffer write data
- frame_ready  out  1  complete frame in buffer
- start_addr  out  AW  address of oldest frame sample
- forced  out  1  frame closed by auto timeout
- busy  out  1  state not IDLE

Function
REQ-004 SHALL implement states IDLE, PRE_FILL, ARMED, POST, DONE.
REQ-005 Writes: wr_en, wr_addr and wr_data SHALL be registered, 1-cycle latency after sample_valid, and only when the state is PRE_FILL, ARMED or POST.
REQ-006 wr_addr SHALL increment by one per write, modulo 256, and SHALL never be cleared between frames.
REQ-007 IDLE -> PRE_FILL on arm=1 with mode!=OFF; IDLE -> ARMED directly when pre_trig=0; arm SHALL be ignored in every other state.
REQ-008 PRE_FILL -> ARMED on the valid sample that makes the write count equal pre_trig; no trigger detection in PRE_FILL.
REQ-009 Rising detect: arm-flag sets on a valid sample < max(level-HYST,0); trigger on the next valid sample >= level while the flag is set; the flag clears on trigger.
REQ-010 Falling detect SHALL mirror REQ-009: flag sets on a sample > min(level+HYST,4095); trigger on a sample <= level.
REQ-011 The detector flag SHALL clear on entry to PRE_FILL or ARMED.
REQ-012 Comparisons SHALL be unsigned, computed at DW+1 bits; HYST arithmetic SHALL saturate.
REQ-013 ARMED -> POST on trigger; the trigger sample SHALL be written and its address latched as trig_addr.
REQ-014 In AUTO mode the ARMED state SHALL count valid samples; reaching AUTO_TIMEOUT SHALL force the trigger and set forced=1; NORMAL and SINGLE never time out.
REQ-015 POST -> DONE when writes since trigger, including the trigger sample, equal 256-pre_trig.
REQ-016 On entry to DONE, start_addr SHALL be trig_addr-pre_trig mod 256 and frame_ready=1, held until frame_ack.
REQ-017 frame_ready SHALL clear the cycle after frame_ack=1; forced SHALL clear at the same time.
REQ-018 After ack, SINGLE -> IDLE; AUTO and NORMAL -> PRE_FILL (ARMED if pre_trig=0) with no arm pulse needed.
REQ-019 frame_ack outside DONE SHALL be ignored.
REQ-020 mode=OFF in any state SHALL force IDLE next cycle: no frame_ready, counters cleared, any in-flight registered write still completes.
REQ-021 mode and pre_trig SHALL be sampled on leaving IDLE or DONE; later changes other than to OFF take effect on the next frame.
REQ-022 busy SHALL be 1 in every state except IDLE.

Reset
REQ-023 rst=0 SHALL asynchronously set state IDLE and all outputs, counters, trig_addr and the detector flag to 0.
REQ-024 Reset mid-capture SHALL discard the frame; after release the block SHALL wait in IDLE for arm.

Structure
REQ-025 Shared package osc_pkg SHALL hold the capture_state_t enum, the mode encodings (MODE_OFF/AUTO/NORMAL/SINGLE), and the DW/AW constants.
REQ-026 Hysteresis edge detection SHALL be a sub-module trig_detect (sample, valid, level, edge_sel, clear -> hit).

Verification
REQ-027 SINGLE, rising, level=2048, pre_trig=64, ramp 0..4095 -> trigger at sample 2048, start_addr=trig_addr-64, exactly 256 writes, frame_ready=1, then IDLE after ack.
REQ-028 NORMAL, falling, level=1000, samples sitting between 995 and 1005 -> no trigger (hysteresis holds); drop to 900 after 1100 -> trigger.
REQ-029 AUTO, constant 0, level=2048 -> forced=1 after 50000 valid samples plus 256-pre_trig post writes; auto re-arm after ack.
REQ-030 pre_trig=0 -> arm goes straight to ARMED; pre_trig=255 -> DONE after exactly 1 post-trigger write.
REQ-031 mode to OFF during POST -> IDLE next cycle, frame_ready stays 0; rst=0 during ARMED -> all outputs 0 asynchronously.
REQ-032 wr_addr wrap: three NORMAL frames back-to-back -> addresses continue across 255->0; start_addr is correct modulo 256.

Source files
------------

// File: rtl/osc_pkg.sv
// Shared oscilloscope types: capture FSM states, acquisition mode encodings
// and the default sample/address widths.
package osc_pkg;

  localparam int DW = 12;
  localparam int AW = 8;

  typedef enum logic [2:0] {
    IDLE,
    PRE_FILL,
    ARMED,
    POST,
    DONE
  } capture_state_t;

  localparam logic [1:0] MODE_OFF    = 2'b00;
  localparam logic [1:0] MODE_AUTO   = 2'b01;
  localparam logic [1:0] MODE_NORMAL = 2'b10;
  localparam logic [1:0] MODE_SINGLE = 2'b11;

endpackage

// File: rtl/trig_detect.sv
// Hysteresis edge detector: a sample must first leave the band around the
// level on the far side before a crossing of the level counts as a trigger.
module trig_detect #(
  parameter int DW   = 12,
  parameter int HYST = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] sample,
  input  logic          valid,
  input  logic [DW-1:0] level,
  input  logic          edge_sel,
  input  logic          clear,
  output logic          hit
);

  localparam logic [DW:0] MAX_S  = {1'b0, {DW{1'b1}}};
  localparam logic [DW:0] HYST_W = (DW+1)'(HYST);

  logic [DW:0] s_w, lvl_w, lo_thr, hi_sum, hi_thr;
  logic        primed_q, set_cond, hit_cond;

  // One extra bit keeps level +/- HYST from wrapping before saturation.
  always_comb begin
    s_w    = {1'b0, sample};
    lvl_w  = {1'b0, level};
    lo_thr = (lvl_w >= HYST_W) ? (lvl_w - HYST_W) : '0;
    hi_sum = lvl_w + HYST_W;
    hi_thr = (hi_sum > MAX_S) ? MAX_S : hi_sum;
    if (!edge_sel) begin
      set_cond = s_w < lo_thr;
      hit_cond = s_w >= lvl_w;
    end else begin
      set_cond = s_w > hi_thr;
      hit_cond = s_w <= lvl_w;
    end
    hit = valid && primed_q && hit_cond;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                      primed_q <= 1'b0;
    else if (clear)                primed_q <= 1'b0;
    else if (hit)                  primed_q <= 1'b0;
    else if (valid && set_cond)    primed_q <= 1'b1;
  end

endmodule

// File: rtl/capture_ctrl.sv
// Capture controller: streams samples into a circular buffer with a
// pre-trigger window, closes a frame after the trigger and hands it over.
module capture_ctrl #(
  parameter int DW           = osc_pkg::DW,
  parameter int AW           = osc_pkg::AW,
  parameter int HYST         = 6,
  parameter int AUTO_TIMEOUT = 50000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    mode,
  input  logic          edge_sel,
  input  logic [DW-1:0] level,
  input  logic [AW-1:0] pre_trig,
  input  logic          arm,
  input  logic          sample_valid,
  input  logic [DW-1:0] sample,
  input  logic          frame_ack,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [DW-1:0] wr_data,
  output logic          frame_ready,
  output logic [AW-1:0] start_addr,
  output logic          forced,
  output logic          busy
);
  import osc_pkg::*;

  localparam int          TW    = $clog2(AUTO_TIMEOUT + 1);
  localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

  capture_state_t state_q, state_d;

  logic [1:0]    mode_q;
  logic [AW-1:0] pre_q;
  logic [AW-1:0] wr_ptr, trig_addr, trig_addr_d;
  logic [AW:0]   fill_cnt, fill_inc, post_target;
  logic [TW-1:0] to_cnt;
  logic          capturing, write_go, det_valid, det_clear, hit;
  logic          timeout_hit, trig, state_change, cfg_take;

  always_comb begin
    capturing    = state_q inside {PRE_FILL, ARMED, POST};
    write_go     = sample_valid && capturing;
    fill_inc     = fill_cnt + 1'b1;
    post_target  = DEPTH - {1'b0, pre_q};
    det_valid    = sample_valid && (state_q == ARMED);
    timeout_hit  = det_valid && (mode_q == MODE_AUTO) && (to_cnt == TW'(AUTO_TIMEOUT - 1));
    trig         = hit || timeout_hit;
    trig_addr_d  = trig ? wr_ptr : trig_addr;
    state_change = state_d != state_q;
    det_clear    = state_change && (state_d inside {PRE_FILL, ARMED});
    cfg_take     = (state_q inside {IDLE, DONE}) && (state_d inside {PRE_FILL, ARMED});
  end

  trig_detect #(
    .DW   (DW),
    .HYST (HYST)
  ) u_trig_detect (
    .clk      (clk),
    .rst      (rst),
    .sample   (sample),
    .valid    (det_valid),
    .level    (level),
    .edge_sel (edge_sel),
    .clear    (det_clear),
    .hit      (hit)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    // NOTE: default-first assignment keeps this block free of inferred latches.
    state_d = state_q;
    if (mode == MODE_OFF) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:     if (arm) state_d = (pre_trig == '0) ? ARMED : PRE_FILL;
        PRE_FILL: if (sample_valid && (fill_inc == {1'b0, pre_q})) state_d = ARMED;
        ARMED:    if (trig) state_d = (post_target == (AW+1)'(1)) ? DONE : POST;
        POST:     if (sample_valid && (fill_inc == post_target)) state_d = DONE;
        DONE: begin
          if (frame_ack) begin
            case (mode_q)
              MODE_AUTO, MODE_NORMAL: state_d = (pre_trig == '0) ? ARMED : PRE_FILL;
              default:                state_d = IDLE;
            endcase
          end
        end
        default:  state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    frame_ready = (state_q == DONE);
    busy        = (state_q != IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      wr_ptr     <= '0;
      trig_addr  <= '0;
      start_addr <= '0;
      forced     <= 1'b0;
      mode_q     <= MODE_OFF;
      pre_q      <= '0;
      fill_cnt   <= '0;
      to_cnt     <= '0;
    end else begin
      // The buffer pointer runs freely across frames; only reset rewinds it.
      wr_en <= write_go;
      if (write_go) begin
        wr_addr <= wr_ptr;
        wr_data <= sample;
        wr_ptr  <= wr_ptr + 1'b1;
      end

      if (cfg_take) begin
        mode_q <= mode;
        pre_q  <= pre_trig;
      end

      if (state_change)
        fill_cnt <= (state_d == POST) ? (AW+1)'(1) : '0;
      else if (sample_valid && (state_q inside {PRE_FILL, POST}))
        fill_cnt <= fill_inc;

      if ((state_q == ARMED) && (state_d == ARMED)) begin
        if (sample_valid) to_cnt <= to_cnt + 1'b1;
      end else begin
        to_cnt <= '0;
      end

      trig_addr <= trig_addr_d;
      if (state_change && (state_d == DONE))
        start_addr <= trig_addr_d - pre_q;

      if (!(state_d inside {POST, DONE}))
        forced <= 1'b0;
      else if (trig)
        forced <= timeout_hit && !hit;
    end
  end

endmodule

// File: tb/tb_capture_ctrl.sv
// Directed bench for capture_ctrl: single, normal, auto and boundary frames,
// with a shadow buffer built from the write port.
module tb_capture_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  mode;
  logic        edge_sel;
  logic [11:0] level;
  logic [7:0]  pre_trig;
  logic        arm;
  logic        sample_valid;
  logic [11:0] sample;
  logic        frame_ack;
  logic        wr_en;
  logic [7:0]  wr_addr;
  logic [11:0] wr_data;
  logic        frame_ready;
  logic [7:0]  start_addr;
  logic        forced;
  logic        busy;

  capture_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .mode         (mode),
    .edge_sel     (edge_sel),
    .level        (level),
    .pre_trig     (pre_trig),
    .arm          (arm),
    .sample_valid (sample_valid),
    .sample       (sample),
    .frame_ack    (frame_ack),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .frame_ready  (frame_ready),
    .start_addr   (start_addr),
    .forced       (forced),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [11:0] mem [256];
  int          wr_count = 0;
  int          addr_err = 0;
  logic [7:0]  exp_addr = '0;
  logic [7:0]  last_addr = '0;

  // Shadow buffer and address-continuity tracker, sampled off the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      exp_addr = '0;
    end else if (wr_en) begin
      if (wr_addr != exp_addr) addr_err++;
      mem[wr_addr] = wr_data;
      wr_count++;
      last_addr = wr_addr;
      exp_addr  = wr_addr + 8'd1;
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  task automatic drv(input logic v, input logic [11:0] s);
    sample_valid = v;
    sample       = s;
    @(negedge clk);
  endtask

  task automatic pulse_arm();
    arm = 1'b1;
    drv(1'b0, 12'd0);
    arm = 1'b0;
  endtask

  task automatic pulse_ack();
    frame_ack = 1'b1;
    drv(1'b0, 12'd0);
    frame_ack = 1'b0;
  endtask

  task automatic wait_ready(input int max_n, input logic [11:0] s, output int k);
    k = -1;
    for (int j = 0; j < max_n; j++) begin
      drv(1'b1, s);
      if (frame_ready) begin
        k = j;
        break;
      end
    end
  endtask

  task automatic normal_frame(input int npre, output int k);
    repeat (npre) drv(1'b1, 12'd1100);
    drv(1'b1, 12'd1100);
    drv(1'b1, 12'd900);
    wait_ready(300, 12'd800, k);
    drv(1'b0, 12'd0);
  endtask

  initial begin
    int k;
    int c0;
    int early;
    int jit [10] = '{995, 1005, 1000, 1006, 998, 1003, 1000, 1006, 1000, 995};

    rst = 1'b0; mode = 2'b00; edge_sel = 1'b0; level = '0; pre_trig = '0;
    arm = 1'b0; sample_valid = 1'b0; sample = '0; frame_ack = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_ready", frame_ready, 0);
    check("rst_wr_en", wr_en, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_start", start_addr, 0);
    check("rst_forced", forced, 0);
    #3 rst = 1'b1;
    @(negedge clk);

    // SINGLE, rising ramp, level 2048, 64 pre-trigger samples
    mode = 2'b11; edge_sel = 1'b0; level = 12'd2048; pre_trig = 8'd64;
    pulse_arm();
    check("single_busy", busy, 1);
    k = -1;
    for (int i = 0; i < 4096; i++) begin
      drv(1'b1, 12'(i));
      if (frame_ready) begin
        k = i;
        break;
      end
    end
    check("single_done_sample", k, 2239);
    drv(1'b0, 12'd0);
    repeat (3) drv(1'b1, 12'd100);
    drv(1'b0, 12'd0);
    check("single_wr_count", wr_count, 2240);
    check("single_start", start_addr, 192);
    check("single_oldest", mem[8'd192], 1984);
    check("single_trig_data", mem[8'd0], 2048);
    check("single_newest", mem[8'd191], 2239);
    check("single_last_addr", last_addr, 191);
    check("single_ready", frame_ready, 1);
    check("single_forced", forced, 0);
    pulse_ack();
    check("single_ack_ready", frame_ready, 0);
    check("single_ack_idle", busy, 0);

    // NORMAL, falling, level 1000: jitter inside the band must not trigger
    mode = 2'b10; edge_sel = 1'b1; level = 12'd1000; pre_trig = 8'd0;
    pulse_arm();
    check("normal_busy", busy, 1);
    c0 = wr_count;
    early = 0;
    foreach (jit[i]) begin
      frame_ack = (i == 5);
      drv(1'b1, 12'(jit[i]));
      if (frame_ready) early++;
    end
    frame_ack = 1'b0;
    check("hyst_no_trigger", early, 0);
    normal_frame(0, k);
    check("hyst_post_len", k, 254);
    check("hyst_start", start_addr, 203);
    check("hyst_trig_data", mem[8'd203], 900);
    check("hyst_writes", wr_count - c0, 267);
    pulse_ack();
    check("rearm_busy", busy, 1);
    check("rearm_ready", frame_ready, 0);

    // Back-to-back NORMAL frames across the address wrap
    normal_frame(0, k);
    check("wrap_a_len", k, 254);
    check("wrap_a_start", start_addr, 204);
    pre_trig = 8'd20;
    pulse_ack();
    normal_frame(20, k);
    check("wrap_b_len", k, 234);
    check("wrap_b_start", start_addr, 205);
    check("wrap_b_oldest", mem[8'd205], 1100);
    check("wrap_b_trig", mem[8'd225], 900);
    pulse_ack();
    normal_frame(20, k);
    check("wrap_c_start", start_addr, 206);
    check("wrap_c_trig", mem[8'd226], 900);
    check("wrap_addr_seq", addr_err, 0);
    mode = 2'b00;
    drv(1'b0, 12'd0);
    check("off_from_done_idle", busy, 0);
    check("off_from_done_ready", frame_ready, 0);

    // pre_trig = 255: the trigger sample alone closes the frame
    mode = 2'b11; edge_sel = 1'b0; level = 12'd2048; pre_trig = 8'd255;
    pulse_arm();
    repeat (255) drv(1'b1, 12'd0);
    drv(1'b1, 12'd0);
    drv(1'b0, 12'd0);
    drv(1'b0, 12'd0);
    c0 = wr_count;
    check("pre255_not_ready", frame_ready, 0);
    drv(1'b1, 12'd3000);
    check("pre255_ready", frame_ready, 1);
    repeat (3) drv(1'b1, 12'd5);
    drv(1'b0, 12'd0);
    check("pre255_post_writes", wr_count - c0, 1);
    check("pre255_start", start_addr, 207);
    check("pre255_trig_data", mem[8'd206], 3000);
    pulse_ack();
    check("pre255_idle", busy, 0);

    // mode OFF during POST: straight to IDLE, in-flight write completes
    mode = 2'b10; edge_sel = 1'b0; level = 12'd2048; pre_trig = 8'd0;
    pulse_arm();
    drv(1'b1, 12'd0);
    drv(1'b1, 12'd3000);
    repeat (10) drv(1'b1, 12'd5);
    mode = 2'b00;
    drv(1'b1, 12'd7);
    check("off_inflight_wr", wr_en, 1);
    check("off_idle", busy, 0);
    check("off_ready", frame_ready, 0);
    drv(1'b1, 12'd7);
    check("off_no_wr", wr_en, 0);
    mode = 2'b10;
    repeat (5) drv(1'b1, 12'd7);
    check("off_stays_idle", busy, 0);
    check("off_stays_unready", frame_ready, 0);

    // Asynchronous reset while ARMED
    pulse_arm();
    repeat (3) drv(1'b1, 12'd0);
    #2 rst = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_wr_en", wr_en, 0);
    check("arst_wr_addr", wr_addr, 0);
    check("arst_start", start_addr, 0);
    check("arst_ready", frame_ready, 0);
    @(negedge clk);
    #3 rst = 1'b1;
    @(negedge clk);
    c0 = wr_count;
    repeat (5) drv(1'b1, 12'd9);
    drv(1'b0, 12'd0);
    check("arst_waits_arm", busy, 0);
    check("arst_no_writes", wr_count - c0, 0);

    // AUTO with a flat input: forced trigger after the timeout
    mode = 2'b01; edge_sel = 1'b0; level = 12'd2048; pre_trig = 8'd8;
    pulse_arm();
    k = -1;
    for (int j = 0; j < 51000; j++) begin
      drv(1'b1, 12'd0);
      if (j == 1000) check("auto_not_forced_yet", forced, 0);
      if (frame_ready) begin
        k = j;
        break;
      end
    end
    check("auto_done_sample", k, 50254);
    drv(1'b0, 12'd0);
    check("auto_forced", forced, 1);
    check("auto_start", start_addr, 79);
    check("auto_last_addr", last_addr, 78);
    pulse_ack();
    check("auto_ack_ready", frame_ready, 0);
    check("auto_ack_forced", forced, 0);
    check("auto_rearm_busy", busy, 1);
    check("final_addr_seq", addr_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
